// File: rtl/dense_streaming.sv
// dense_streaming: streaming fully-connected layer with requantised outputs.
//
// Activations arrive one per accepted cycle with their flat index. Each index
// drives a combinational weight-row read; the row returns one cycle later and
// is multiplied against the registered activation for all NOUT neurons in
// parallel. After the last index the sums are biased, arithmetically shifted,
// saturated to DATA_W and held on out_vec. out_valid pulses three cycles after
// the cycle carrying the last input.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data/in_index   activation stream
//   w_rd_en/w_addr      weight-row read request (combinational copy of input)
//   w_data              weight row, one cycle after w_rd_en
//   bias                per-neuron bias, static during a frame
//   out_valid/out_vec   result pulse and held requantised logits
//   out_class           argmax of out_vec (zero unless DENSE_ARGMAX_EN)
//   busy, err           not-idle flag, sticky per-frame protocol error
//
// Optional feature: define DENSE_ARGMAX_EN to build the argmax comparator.
module dense_streaming #(
  parameter int IN_LEN = 1568,
  parameter int NOUT   = 10,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [DATA_W-1:0]      in_data,
  input  logic [$clog2(IN_LEN)-1:0]     in_index,
  output logic                          w_rd_en,
  output logic [$clog2(IN_LEN)-1:0]     w_addr,
  input  logic signed [DATA_W-1:0]      w_data [NOUT],
  input  logic signed [ACC_W-1:0]       bias   [NOUT],
  output logic                          out_valid,
  output logic signed [DATA_W-1:0]      out_vec [NOUT],
  output logic [$clog2(NOUT)-1:0]       out_class,
  output logic                          busy,
  output logic                          err
);

  localparam int IW = $clog2(IN_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(IN_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_OUTPUT} state_t;

  state_t                     state_q, state_d;
  logic                       in_v_q, in_v_d;
  logic signed [DATA_W-1:0]   in_data_q, in_data_d;
  logic [IW-1:0]              exp_q, exp_d;
  logic                       err_q, err_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]    acc_q [NOUT];
  logic signed [ACC_W-1:0]    acc_d [NOUT];
  logic signed [DATA_W-1:0]   out_vec_q [NOUT];
  logic signed [DATA_W-1:0]   out_vec_d [NOUT];

  logic signed [2*DATA_W-1:0] prod    [NOUT];
  logic signed [ACC_W-1:0]    mac     [NOUT];
  logic signed [ACC_W-1:0]    sum     [NOUT];
  logic signed [ACC_W-1:0]    shifted [NOUT];
  logic signed [DATA_W-1:0]   sat_v   [NOUT];

  // Stage-2 MAC plus requantisation. In FINISH the last product is still in
  // flight, so requantisation works from the post-MAC value rather than acc_q.
  always_comb begin
    for (int unsigned n = 0; n < NOUT; n++) begin
      prod[n]    = in_data_q * w_data[n];
      mac[n]     = in_v_q ? acc_q[n] + ACC_W'(prod[n]) : acc_q[n];
      sum[n]     = mac[n] + bias[n];
      shifted[n] = sum[n] >>> SHIFT;
      if (shifted[n] > SAT_MAX)      sat_v[n] = SAT_MAX[DATA_W-1:0];
      else if (shifted[n] < SAT_MIN) sat_v[n] = SAT_MIN[DATA_W-1:0];
      else                           sat_v[n] = shifted[n][DATA_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    in_v_d      = 1'b0;
    in_data_d   = in_data_q;
    exp_d       = exp_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    acc_d       = mac;
    out_vec_d   = out_vec_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_index == '0) begin
            for (int unsigned n = 0; n < NOUT; n++) acc_d[n] = '0;
            err_d     = 1'b0;
            exp_d     = IW'(1);
            in_v_d    = 1'b1;
            in_data_d = in_data;
            state_d   = S_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          in_v_d    = 1'b1;
          in_data_d = in_data;
          exp_d     = exp_q + IW'(1);
          if (in_index != exp_q) err_d = 1'b1;
          if (in_index == LAST_IDX) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        out_vec_d = sat_v;
        if (in_valid) err_d = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (in_valid) err_d = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_v_q      <= 1'b0;
      in_data_q   <= '0;
      exp_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned n = 0; n < NOUT; n++) begin
        acc_q[n]     <= '0;
        out_vec_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_v_q      <= in_v_d;
      in_data_q   <= in_data_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      out_vec_q   <= out_vec_d;
    end
  end

`ifdef DENSE_ARGMAX_EN
  localparam int CW = $clog2(NOUT);
  logic [CW-1:0]            class_q, class_d, best_idx;
  logic signed [DATA_W-1:0] best_val;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = sat_v[0];
    for (int unsigned n = 1; n < NOUT; n++) begin
      if (sat_v[n] > best_val) begin
        best_idx = CW'(n);
        best_val = sat_v[n];
      end
    end
    class_d = (state_q == S_FINISH) ? best_idx : class_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) class_q <= '0;
    else        class_q <= class_d;
  end

  assign out_class = class_q;
`else
  assign out_class = '0;
`endif

  assign w_rd_en   = in_valid;
  assign w_addr    = in_index;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_dense_streaming.sv
module tb_dense_streaming;
  localparam int IN_LEN = 1568;
  localparam int NOUT   = 10;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int SHIFT  = 8;
  localparam int IW     = $clog2(IN_LEN);
  localparam int CW     = $clog2(NOUT);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic [IW-1:0]            in_index;
  logic                     w_rd_en;
  logic [IW-1:0]            w_addr;
  logic signed [DATA_W-1:0] w_data [NOUT];
  logic signed [ACC_W-1:0]  bias   [NOUT];
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_vec [NOUT];
  logic [CW-1:0]            out_class;
  logic                     busy;
  logic                     err;

  dense_streaming #(.IN_LEN(IN_LEN), .NOUT(NOUT), .DATA_W(DATA_W),
                    .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_index(in_index), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .bias(bias), .out_valid(out_valid), .out_vec(out_vec),
    .out_class(out_class), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Bench-side weight memory and activation table.
  logic signed [DATA_W-1:0] wmem [IN_LEN][NOUT];
  logic signed [DATA_W-1:0] act  [IN_LEN];

  always @(posedge clk)
    if (w_rd_en)
      for (int n = 0; n < NOUT; n++) w_data[n] <= wmem[w_addr][n];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks  = 0;
  int nfail    = 0;
  int npushed  = 0;
  int npulses  = 0;

  task automatic check(input string name, input longint actv, input longint expv);
    nchecks++;
    if (actv !== expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actv, expv, cyc);
    end
  endtask

  typedef struct packed {
    int                        pcyc;
    logic [NOUT-1:0][DATA_W-1:0] v;
    logic [CW-1:0]             cls;
  } exp_t;

  exp_t q[$];
  logic [NOUT-1:0][DATA_W-1:0] held_v = '0;
  logic [CW-1:0]               held_c = '0;

  // Compare process: pulse timing, interface pass-through and held results.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("w_rd_en", w_rd_en, in_valid);
      check("w_addr", w_addr, in_index);
      while (q.size() > 0 && q[0].pcyc < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].pcyc <= cyc + 1) begin
        held_v = q[0].v;
        held_c = q[0].cls;
      end
      if (out_valid) npulses++;
      check("out_valid", out_valid, (q.size() > 0 && q[0].pcyc == cyc));
      for (int n = 0; n < NOUT; n++)
        check("out_vec", out_vec[n], $signed(held_v[n]));
      check("out_class", out_class, held_c);
      if (q.size() > 0 && q[0].pcyc == cyc) void'(q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Sends one frame and queues its expected result. skip_idx drops one index,
  // abort_at pulses reset in place of that index, extra_drop sends one input
  // during FINISH.
  task automatic run_frame(input int skip_idx, input int abort_at,
                           input int gap_pct, input bit extra_drop);
    int   acc [NOUT];
    int   last;
    int   s;
    int   best;
    exp_t e;
    for (int n = 0; n < NOUT; n++) acc[n] = 0;
    last = 0;
    for (int i = 0; i < IN_LEN; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        held_v   = '0;
        held_c   = '0;
        tick();
        check("busy_in_reset", busy, 0);
        check("err_in_reset", err, 0);
        rst_n = 1'b1;
        tick();
        return;
      end
      if (i == skip_idx) continue;
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        tick();
      end
      if (i == 1) begin
        check("busy_mid_frame", busy, 1);
        check("err_cleared_at_start", err, 0);
      end
      if (skip_idx >= 0 && i == skip_idx + 2) check("err_after_skip", err, 1);
      in_valid = 1'b1;
      in_data  = act[i];
      in_index = IW'(i);
      for (int n = 0; n < NOUT; n++) acc[n] += int'(act[i]) * int'(wmem[i][n]);
      last = cyc;
      tick();
    end
    best = 0;
    for (int n = 0; n < NOUT; n++) begin
      s = acc[n] + int'(bias[n]);
      s = sat8(s >>> SHIFT);
      e.v[n] = DATA_W'(s);
      if ($signed(e.v[n]) > $signed(e.v[best])) best = n;
    end
`ifdef DENSE_ARGMAX_EN
    e.cls = CW'(best);
`else
    e.cls = '0;
`endif
    e.pcyc = last + 3;
    q.push_back(e);
    npushed++;
    in_valid = extra_drop;
    in_index = '0;
    in_data  = 8'sd5;
    tick();
    in_valid = 1'b0;
    if (extra_drop) check("err_drop_in_finish", err, 1);
    tick();
  endtask

  task automatic wait_done;
    int budget;
    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("out_valid_timeout", q.size(), 0);
    tick();
  endtask

  task automatic fill(input int a, input int w);
    for (int i = 0; i < IN_LEN; i++) begin
      act[i] = DATA_W'(a);
      for (int n = 0; n < NOUT; n++) wmem[i][n] = DATA_W'(w);
    end
  endtask

  task automatic fill_random;
    for (int i = 0; i < IN_LEN; i++) begin
      act[i] = $signed(DATA_W'($urandom));
      for (int n = 0; n < NOUT; n++) wmem[i][n] = $signed(DATA_W'($urandom_range(40, 0))) - 8'sd20;
    end
  endtask

  task automatic expect_all(input string name, input int v);
    for (int n = 0; n < NOUT; n++) check(name, out_vec[n], v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_index = '0;
    for (int n = 0; n < NOUT; n++) begin
      bias[n] = '0;
      w_data[n] = '0;
    end
    fill(0, 0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_out_class", out_class, 0);
    expect_all("rst_out_vec", 0);
    rst_n = 1'b1;
    tick();

    // Non-zero index while idle is ignored and flags err.
    in_valid = 1'b1;
    in_index = IW'(5);
    in_data  = 8'sd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("idle_bad_err", err, 1);
    check("idle_bad_busy", busy, 0);

    // All ones: 1568 >>> 8 = 6; all tie so argmax is index 0.
    fill(1, 1);
    run_frame(-1, -1, 0, 0);
    wait_done();
    expect_all("ones_vec", 6);
    check("ones_class", out_class, 0);
    check("ones_err", err, 0);

    // Positive saturation, with gaps in the stream.
    fill(127, 127);
    run_frame(-1, -1, 30, 0);
    wait_done();
    expect_all("sat_hi_vec", 127);

    // Negative saturation; an input during FINISH must be dropped.
    fill(127, -128);
    run_frame(-1, -1, 0, 1);
    wait_done();
    expect_all("sat_lo_vec", -128);
    check("drop_err_sticky", err, 1);

    // Bias-only result on neuron 3.
    fill(1, 0);
    bias[3] = 32'sd1280;
    run_frame(-1, -1, 0, 0);
    wait_done();
    check("bias_vec3", out_vec[3], 5);
    check("bias_vec0", out_vec[0], 0);
    check("bias_vec9", out_vec[9], 0);
`ifdef DENSE_ARGMAX_EN
    check("bias_class", out_class, 3);
`else
    check("bias_class", out_class, 0);
`endif
    bias[3] = '0;

    // Skipped index 100: err raised, frame still completes.
    fill_random();
    run_frame(100, -1, 0, 0);
    wait_done();
    check("skip_err_held", err, 1);

    // Reset at index 800 discards the frame; the following clean frame stands.
    for (int n = 0; n < NOUT; n++) bias[n] = ACC_W'($signed(32'($urandom_range(4000, 0))) - 2000);
    run_frame(-1, 800, 0, 0);
    check("abort_out_vec0", out_vec[0], 0);
    run_frame(-1, -1, 0, 0);
    wait_done();

    // Two back-to-back frames with gaps and fresh data each.
    fill_random();
    run_frame(-1, -1, 20, 0);
    fill_random();
    run_frame(-1, -1, 20, 0);
    wait_done();

    repeat (5) tick();
    check("pulse_count", npulses, npushed);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
